wb_read_checker: RTL
====================

Name: wb_read_checker

Overview:
- Passive Wishbone monitor. Taps the pipelined bus between the traffic master and the DDR3 controller (ddr3_top), on the controller clock.
- Records accepted requests in order and matches each ack to its request.
- For every completed read, checks the returned data against a deterministic address-derived pattern.
- Reports error counts, the first failing address and protocol faults. Never drives the bus.

Parameters:
- WB_ADDR_BITS, 25, width of burst address {row,bank,col}.
- WB_DATA_BITS, 512, data width; must be a multiple of 32.
- FIFO_AW, 4, log2 depth of the outstanding-request tracker (16 entries).
- SEED, 32'hA5A5_0000, pattern seed.

Ports:
- i_clk  input  1  controller clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  1 = check reads; 0 = track only, no compare or error update.
- i_clear  input  1  synchronous clear of counters and sticky flags; does not flush the tracker.
- i_wb_cyc  input  1  snooped bus cycle.
- i_wb_stb  input  1  snooped strobe.
- i_wb_we  input  1  snooped write enable.
- i_wb_addr  input  WB_ADDR_BITS  snooped address.
- i_wb_stall  input  1  snooped controller stall.
- i_wb_ack  input  1  snooped controller ack.
- i_wb_data  input  WB_DATA_BITS  snooped read data.
- o_read_count  output  32  completed reads checked; saturates at 32'hFFFF_FFFF.
- o_err_count  output  32  mismatching reads; saturating.
- o_err_pulse  output  1  one-cycle pulse per mismatch.
- o_first_err_valid  output  1  sticky; o_first_err_addr is valid.
- o_first_err_addr  output  WB_ADDR_BITS  address of first mismatch since reset/clear.
- o_track_overflow  output  1  sticky; request accepted while tracker full.
- o_protocol_err  output  1  sticky; ack with no outstanding request.
- o_outstanding  output  FIFO_AW+1  current tracker occupancy.

Behaviour:
- Reset: all outputs 0; tracker empty. Reset mid-operation discards outstanding entries immediately.
- Accept = i_wb_cyc & i_wb_stb & !i_wb_stall. It pushes {i_wb_we, i_wb_addr} into the tracker.
- Complete = i_wb_cyc & i_wb_ack. It pops the oldest entry.
- Push and pop in the same cycle: both happen; occupancy unchanged. This holds even when full.
- Push when full, no pop: entry dropped, o_track_overflow <= 1, occupancy stays 2^FIFO_AW.
- Pop when empty: o_protocol_err <= 1, no compare. A same-cycle push is still stored.
- i_wb_cyc = 0: tracker flushed to empty on the next edge; acks and requests in that cycle are ignored. This matches the cancel semantics.
- Expected data: lane k (bits 32k+31:32k, k = 0..WB_DATA_BITS/32-1) = zero-extend-to-32(addr) XOR (SEED + k) mod 2^32.
- Compare pipeline, stage 1 (cycle N): on complete with popped we = 0 and i_enable = 1, register i_wb_data, expected word and addr.
- Compare pipeline, stage 2 (cycle N+1):
  - o_read_count += 1.
  - On inequality: o_err_pulse = 1 and o_err_count += 1.
  - If o_first_err_valid = 0: latch o_first_err_addr and set o_first_err_valid.
- Total latency: ack to error pulse/count is 1 cycle.
- Write completions pop but never compare or count.
- Counters saturate; they do not wrap.
- i_clear at cycle N: counters, first-error and sticky flags are 0 at N+1. A compare result maturing at N+1 is discarded; clear wins. The tracker and o_outstanding are unaffected.
- i_enable = 0 only suppresses the compare stage; tracking continues, so ordering is preserved when re-enabled.
- o_outstanding updates one cycle after the accept/complete edge (registered occupancy).

Test Plan:
- Write addr 0x10 then read 0x10 with correct pattern (lane0 = 0xA5A5_0010, lane1 = 0xA5A5_0011 ...) -> o_read_count = 1, o_err_count = 0, no pulse.
- Read 0x20 returning lane3 bit0 flipped -> o_err_pulse exactly at ack+1, o_err_count = 1, o_first_err_addr = 0x20. A second bad read at 0x30 -> count = 2, addr remains 0x20.
- Issue 17 reads with stall low and no ack -> o_outstanding = 16, o_track_overflow = 1. Then 16 acks -> o_outstanding = 0, no protocol error.
- Ack with empty tracker -> o_protocol_err = 1, o_read_count unchanged. Push and pop in the same cycle at occupancy 16 -> stays 16, no overflow.
- 5 outstanding reads, then drop i_wb_cyc for 1 cycle -> o_outstanding = 0. Later acks set o_protocol_err. Assert i_clear -> all counters and flags 0 next cycle.
- Assert i_rst_n = 0 asynchronously with 3 outstanding reads and a pending mismatch -> all outputs 0 immediately, no o_err_pulse after release.

Source files
------------

// File: rtl/wb_read_checker.sv
// Passive Wishbone read checker. Snoops the pipelined bus between the traffic
// master and the DDR3 controller, tracks accepted requests in order, and
// checks read data returned on each ack against an address-derived pattern.
// Never drives the bus.
module wb_read_checker #(
    parameter int          WB_ADDR_BITS = 25,
    parameter int          WB_DATA_BITS = 512,
    parameter int          FIFO_AW      = 4,
    parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_clear,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [WB_ADDR_BITS-1:0] i_wb_addr,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_ack,
    input  logic [WB_DATA_BITS-1:0] i_wb_data,
    output logic [31:0]             o_read_count,
    output logic [31:0]             o_err_count,
    output logic                    o_err_pulse,
    output logic                    o_first_err_valid,
    output logic [WB_ADDR_BITS-1:0] o_first_err_addr,
    output logic                    o_track_overflow,
    output logic                    o_protocol_err,
    output logic [FIFO_AW:0]        o_outstanding
);

    localparam int               LANES    = WB_DATA_BITS / 32;
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    // Tracker storage: {we, addr} per outstanding request
    logic [WB_ADDR_BITS:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0]      r_wr_ptr;
    logic [FIFO_AW-1:0]      r_rd_ptr;
    logic [FIFO_AW:0]        r_count;

    logic                    w_accept;
    logic                    w_complete;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_pop_err;
    logic                    w_drop;
    logic [WB_ADDR_BITS:0]   w_head;
    logic                    w_head_we;
    logic [WB_ADDR_BITS-1:0] w_head_addr;
    logic [31:0]             w_head_addr32;
    logic [WB_DATA_BITS-1:0] w_exp;
    logic                    w_load;
    logic                    w_mismatch;

    // Compare stage 1 registers
    logic                    r_s1_valid;
    logic [WB_DATA_BITS-1:0] r_s1_data;
    logic [WB_DATA_BITS-1:0] r_s1_exp;
    logic [WB_ADDR_BITS-1:0] r_s1_addr;

    // Result registers
    logic [31:0]             r_read_count;
    logic [31:0]             r_err_count;
    logic                    r_first_err_valid;
    logic [WB_ADDR_BITS-1:0] r_first_err_addr;
    logic                    r_track_overflow;
    logic                    r_protocol_err;

    assign w_accept   = i_wb_cyc & i_wb_stb & ~i_wb_stall;
    assign w_complete = i_wb_cyc & i_wb_ack;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    // A pop on an empty tracker cannot return the entry pushed in the same cycle.
    assign w_pop      = w_complete & ~w_empty;
    assign w_pop_err  = w_complete & w_empty;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push     = w_accept & (~w_full | w_pop);
    assign w_drop     = w_accept & w_full & ~w_pop;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_we   = w_head[WB_ADDR_BITS];
    assign w_head_addr = w_head[WB_ADDR_BITS-1:0];

    // Tracker pointers and occupancy; dropping cyc flushes outstanding requests
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!i_wb_cyc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tracker entry write; contents are meaningless until pushed, so no reset
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_wb_we, i_wb_addr};
    end

    // Expected read data: each 32-bit lane is addr XOR (SEED + lane index)
    always_comb begin
        w_exp         = '0;
        w_head_addr32 = 32'(w_head_addr);
        for (int k = 0; k < LANES; k++) begin
            w_exp[32*k +: 32] = w_head_addr32 ^ (SEED + 32'(k));
        end
    end

    assign w_load = w_pop & ~w_head_we & i_enable;

    // Stage 1 valid flag; cleared by reset so no stale result follows release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_s1_valid <= 1'b0;
        else          r_s1_valid <= w_load;
    end

    // Stage 1 payload capture for the completing read
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_s1_data <= i_wb_data;
            r_s1_exp  <= w_exp;
            r_s1_addr <= w_head_addr;
        end
    end

    assign w_mismatch = r_s1_valid & (r_s1_data != r_s1_exp);

    // Stage 2: saturating counters, first-error capture and sticky faults
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_read_count      <= '0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_addr  <= '0;
            r_track_overflow  <= 1'b0;
            r_protocol_err    <= 1'b0;
        end else if (i_clear) begin
            r_read_count      <= '0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_addr  <= '0;
            r_track_overflow  <= 1'b0;
            r_protocol_err    <= 1'b0;
        end else begin
            if (r_s1_valid && r_read_count != 32'hFFFF_FFFF)
                r_read_count <= r_read_count + 32'd1;
            if (w_mismatch) begin
                if (r_err_count != 32'hFFFF_FFFF)
                    r_err_count <= r_err_count + 32'd1;
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_addr  <= r_s1_addr;
                end
            end
            if (w_drop)    r_track_overflow <= 1'b1;
            if (w_pop_err) r_protocol_err   <= 1'b1;
        end
    end

    assign o_read_count      = r_read_count;
    assign o_err_count       = r_err_count;
    assign o_err_pulse       = w_mismatch;
    assign o_first_err_valid = r_first_err_valid;
    assign o_first_err_addr  = r_first_err_addr;
    assign o_track_overflow  = r_track_overflow;
    assign o_protocol_err    = r_protocol_err;
    assign o_outstanding     = r_count;

endmodule
